// File: rtl/mac_stream_driver_pkg.sv
// Shared types and widths for the mac_unit stream driver.
package mac_stream_driver_pkg;

  localparam int unsigned OpW  = 2;   // operand width
  localparam int unsigned AccW = 8;   // accumulator width
  localparam int unsigned LenW = 4;   // job length width
  localparam int unsigned EntW = 2 * OpW;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous FIFO of {a,b} operand pairs with flush; push+pop allowed when full.
module mac_operand_fifo
  import mac_stream_driver_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [EntW-1:0] wdata,
  input  logic            pop,
  output logic [EntW-1:0] rdata,
  output logic            full,
  output logic            empty
);

  localparam int unsigned AW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = AW + 1;

  logic [EntW-1:0] mem [Depth];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            wr_en, rd_en;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  // A pop in the same cycle frees the slot, so a write into a full FIFO is fine then.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rptr_q];

  // Storage array; no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (rd_en) rptr_q <= rptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mac_stream_driver.sv
// Drives a mac_unit from a job request plus a valid/ready operand stream and
// returns the final accumulator value over a valid/ready result handshake.
module mac_stream_driver
  import mac_stream_driver_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MAC_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [LenW-1:0] len,
  output logic            busy,
  input  logic            in_valid,
  input  logic [OpW-1:0]  in_a,
  input  logic [OpW-1:0]  in_b,
  output logic            in_ready,
  output logic [OpW-1:0]  mac_a,
  output logic [OpW-1:0]  mac_b,
  output logic            mac_enable,
  output logic            mac_clear,
  input  logic [AccW-1:0] mac_out,
  output logic [AccW-1:0] result,
  output logic            result_valid,
  input  logic            result_ready
);

  localparam int unsigned DrainW = $clog2(MAC_LATENCY + 1) + 1;

  state_e            state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   accepted_q, accepted_d;
  logic [LenW-1:0]   issued_q, issued_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [OpW-1:0]    mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic              mac_enable_q, mac_enable_d;
  logic              mac_clear_q, mac_clear_d;
  logic [AccW-1:0]   result_q, result_d;
  logic              result_valid_q, result_valid_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [EntW-1:0]   fifo_rdata;

  assign in_ready  = ((state_q == StClear) || (state_q == StRun)) && !fifo_full &&
                     (accepted_q < len_q);
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_q == StRun) && !fifo_empty && (issued_q < len_q);

  mac_operand_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata ({in_a, in_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, counters and registered mac_unit/result outputs.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    accepted_d     = accepted_q;
    issued_d       = issued_q;
    drain_d        = drain_q;
    mac_a_d        = mac_a_q;
    mac_b_d        = mac_b_q;
    mac_enable_d   = 1'b0;
    mac_clear_d    = 1'b0;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    fifo_flush     = 1'b0;

    if (fifo_push) accepted_d = accepted_q + LenW'(1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d       = (len == '0) ? LenW'(1) : len;
          accepted_d  = '0;
          issued_d    = '0;
          fifo_flush  = 1'b1;
          mac_clear_d = 1'b1;  // lines up with the single CLEAR cycle
          state_d     = StClear;
        end
      end
      StClear: state_d = StRun;
      StRun: begin
        if (fifo_pop) begin
          mac_a_d      = fifo_rdata[EntW-1:OpW];
          mac_b_d      = fifo_rdata[OpW-1:0];
          mac_enable_d = 1'b1;
          issued_d     = issued_q + LenW'(1);
          if (issued_d == len_q) begin
            drain_d = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // First DRAIN cycle is the final enable cycle; mac_out is valid MAC_LATENCY later.
        if (drain_q == DrainW'(MAC_LATENCY)) begin
          result_d       = mac_out;
          result_valid_d = 1'b1;
          state_d        = StDone;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      StDone: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      len_q          <= '0;
      accepted_q     <= '0;
      issued_q       <= '0;
      drain_q        <= '0;
      mac_a_q        <= '0;
      mac_b_q        <= '0;
      mac_enable_q   <= 1'b0;
      mac_clear_q    <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      accepted_q     <= accepted_d;
      issued_q       <= issued_d;
      drain_q        <= drain_d;
      mac_a_q        <= mac_a_d;
      mac_b_q        <= mac_b_d;
      mac_enable_q   <= mac_enable_d;
      mac_clear_q    <= mac_clear_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign mac_a        = mac_a_q;
  assign mac_b        = mac_b_q;
  assign mac_enable   = mac_enable_q;
  assign mac_clear    = mac_clear_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mac_stream_driver.sv
// Directed bench for mac_stream_driver with a behavioural mac_unit attached.
module tb_mac_stream_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic       busy;
  logic       in_valid;
  logic [1:0] in_a, in_b;
  logic       in_ready;
  logic [1:0] mac_a, mac_b;
  logic       mac_enable, mac_clear;
  logic [7:0] mac_out;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt;
  int acc_cnt;
  logic [1:0] pa [16];
  logic [1:0] pb [16];

  always #5 clk = ~clk;

  mac_stream_driver #(
    .FIFO_DEPTH  (4),
    .MAC_LATENCY (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .len          (len),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_ready     (in_ready),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_enable   (mac_enable),
    .mac_clear    (mac_clear),
    .mac_out      (mac_out),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  // Behavioural mac_unit: registered accumulate, one cycle of latency.
  logic [7:0] acc = 8'd0;
  always @(posedge clk) begin
    if (mac_clear)       acc <= 8'd0;
    else if (mac_enable) acc <= acc + 8'(mac_a) * 8'(mac_b);
  end
  assign mac_out = acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mac_enable === 1'b1) en_cnt++;
  endtask

  // Starts a job and offers npairs pairs; stops early once abort_en enables were seen.
  task automatic run_job(input int l, input int npairs, input bit gap, input int limit,
                         input int abort_en);
    int  i;
    int  cyc;
    logic took;
    en_cnt  = 0;
    acc_cnt = 0;
    start   = 1'b1;
    len     = 4'(l);
    step();
    start = 1'b0;
    chk("clear_pulse", {31'd0, mac_clear}, 1);
    chk("clear_no_en", {31'd0, mac_enable}, 0);
    chk("busy_in_clear", {31'd0, busy}, 1);
    i   = 0;
    cyc = 0;
    while (i < npairs && cyc < limit) begin
      in_valid = 1'b1;
      in_a     = pa[i];
      in_b     = pb[i];
      took     = in_ready;
      step();
      cyc++;
      if (abort_en > 0 && en_cnt >= abort_en) break;
      if (took) begin
        i++;
        acc_cnt++;
        if (gap) begin
          in_valid = 1'b0;
          step();
          cyc++;
        end
      end
    end
    if (abort_en == 0) in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int k;
    k = 0;
    while (result_valid !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk(tag, {31'd0, result_valid}, 1);
  endtask

  task automatic consume();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("idle_after_ready", {31'd0, busy}, 0);
    chk("rv_cleared", {31'd0, result_valid}, 0);
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    len          = 4'd0;
    in_valid     = 1'b0;
    in_a         = 2'd0;
    in_b         = 2'd0;
    result_ready = 1'b0;
    en_cnt       = 0;
    acc_cnt      = 0;
    #12;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_mac_enable", {31'd0, mac_enable}, 0);
    chk("rst_mac_clear", {31'd0, mac_clear}, 0);
    chk("rst_result_valid", {31'd0, result_valid}, 0);
    chk("rst_result", {24'd0, result}, 0);
    chk("rst_mac_ab", {28'd0, mac_a, mac_b}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    // Basic: (1,1),(2,2),(3,3) -> 14
    pa[0] = 2'd1; pb[0] = 2'd1;
    pa[1] = 2'd2; pb[1] = 2'd2;
    pa[2] = 2'd3; pb[2] = 2'd3;
    run_job(3, 3, 1'b0, 60, 0);
    chk("basic_accepts", acc_cnt, 3);
    wait_result("basic_rv");
    chk("basic_result", {24'd0, result}, 14);
    chk("basic_enables", en_cnt, 3);
    step();
    step();
    chk("basic_rv_held", {31'd0, result_valid}, 1);
    consume();
    chk("basic_result_kept", {24'd0, result}, 14);

    // Max length: 15 x (3,3) with a 16th pair offered -> 135
    for (int j = 0; j < 16; j++) begin
      pa[j] = 2'd3;
      pb[j] = 2'd3;
    end
    run_job(15, 16, 1'b0, 60, 0);
    chk("max_accepts", acc_cnt, 15);
    chk("max_in_ready_low", {31'd0, in_ready}, 0);
    wait_result("max_rv");
    chk("max_result", {24'd0, result}, 135);
    chk("max_enables", en_cnt, 15);
    consume();

    // Bubbles: 6 x (1,2) with in_valid gaps -> 12
    for (int j = 0; j < 6; j++) begin
      pa[j] = 2'd1;
      pb[j] = 2'd2;
    end
    run_job(6, 6, 1'b1, 80, 0);
    chk("gap_accepts", acc_cnt, 6);
    wait_result("gap_rv");
    chk("gap_result", {24'd0, result}, 12);
    chk("gap_enables", en_cnt, 6);
    consume();

    // Host stall: (2,3),(1,1) -> 7, start during stall ignored
    pa[0] = 2'd2; pb[0] = 2'd3;
    pa[1] = 2'd1; pb[1] = 2'd1;
    run_job(2, 2, 1'b0, 60, 0);
    wait_result("stall_rv");
    for (int j = 0; j < 10; j++) begin
      if (j == 4) begin
        start = 1'b1;
        len   = 4'd3;
      end
      step();
      start = 1'b0;
      chk("stall_result", {24'd0, result}, 7);
      chk("stall_busy", {31'd0, busy}, 1);
    end
    chk("stall_no_clear", {31'd0, mac_clear}, 0);
    consume();
    step();
    chk("stall_start_dropped", {31'd0, busy}, 0);

    // Reset mid-RUN after two enables
    for (int j = 0; j < 5; j++) begin
      pa[j] = 2'd1;
      pb[j] = 2'd1;
    end
    run_job(5, 5, 1'b0, 60, 2);
    chk("abort_reached_2en", en_cnt, 2);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_in_ready", {31'd0, in_ready}, 0);
    chk("abort_mac_enable", {31'd0, mac_enable}, 0);
    chk("abort_mac_clear", {31'd0, mac_clear}, 0);
    chk("abort_mac_ab", {28'd0, mac_a, mac_b}, 0);
    chk("abort_result", {24'd0, result}, 0);
    chk("abort_result_valid", {31'd0, result_valid}, 0);
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("abort_no_result", {31'd0, result_valid}, 0);
    pa[0] = 2'd3; pb[0] = 2'd2;
    run_job(1, 1, 1'b0, 60, 0);
    wait_result("post_abort_rv");
    chk("post_abort_result", {24'd0, result}, 6);
    chk("post_abort_enables", en_cnt, 1);
    consume();

    // len=0 behaves as len=1; second pair refused
    pa[0] = 2'd2; pb[0] = 2'd2;
    pa[1] = 2'd1; pb[1] = 2'd3;
    run_job(0, 2, 1'b0, 20, 0);
    chk("len0_accepts", acc_cnt, 1);
    wait_result("len0_rv");
    chk("len0_result", {24'd0, result}, 4);
    chk("len0_enables", en_cnt, 1);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_stream_driver.md
Name: mac_stream_driver

Overview:
- Initiator-side controller for the existing mac_unit accumulator.
- Accepts a dot-product job (vector length) plus a stream of 2-bit operand pairs over valid/ready, buffers them in a small FIFO and drives the mac_unit a/b/enable/reset pins.
- Captures the final 8-bit accumulator value and presents it to the host over a valid/ready result handshake.
- Sits between the host/sequencer logic and one mac_unit instance.

Parameters:
- FIFO_DEPTH, 4, operand FIFO entries; power of two, at least 2.
- MAC_LATENCY, 1, cycles from the last mac_enable cycle until mac_out reflects that product.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; low clears all state.
- start  input  1  job request, sampled in IDLE only.
- len  input  4  vector length for the job; 1..15 valid, 0 treated as 1.
- busy  output  1  high whenever state is not IDLE.
- in_valid  input  1  operand pair valid.
- in_a  input  2  operand a.
- in_b  input  2  operand b.
- in_ready  output  1  driver can accept an operand pair this cycle.
- mac_a  output  2  registered to mac_unit a.
- mac_b  output  2  registered to mac_unit b.
- mac_enable  output  1  registered to mac_unit enable.
- mac_clear  output  1  registered to mac_unit reset; active-high, one cycle.
- mac_out  input  8  mac_unit accumulator output.
- result  output  8  captured dot product.
- result_valid  output  1  result is valid.
- result_ready  input  1  host consumes the result.

Behaviour:
- Reset (reset low, asynchronous), all outputs go to these values:
  - mac_a=0, mac_b=0, mac_enable=0, mac_clear=0.
  - result=0, result_valid=0, in_ready=0, busy=0.
  - FIFO empty, counters 0, state IDLE.
- State machine: IDLE -> CLEAR -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches len into len_q (0 becomes 1) and clears accepted_cnt and issued_cnt.
  - Next state is CLEAR.
- CLEAR: exactly one cycle with mac_clear=1 and mac_enable=0, then RUN.
- Operand acceptance:
  - in_ready = (state is CLEAR or RUN) AND FIFO not full AND accepted_cnt < len_q.
  - A pair is accepted on an edge where in_valid AND in_ready; accepted_cnt increments.
  - Once len_q pairs are accepted, in_ready stays 0 and extra in_valid is ignored.
- Issue (RUN):
  - When the FIFO is non-empty and issued_cnt < len_q, pop the head; on the next edge register mac_a/mac_b and set mac_enable=1 for that cycle. issued_cnt increments.
  - One pop per cycle maximum; mac_enable=0 in any cycle with no pop.
  - Minimum latency from acceptance edge to mac_enable high is 2 edges: FIFO write, then pop/register.
  - Simultaneous push and pop on the same edge is legal in every occupancy state, including full with pop.
- RUN -> DRAIN on the edge where issued_cnt reaches len_q.
- DRAIN:
  - mac_enable=0; wait MAC_LATENCY+1 cycles, counting from the final mac_enable cycle.
  - Then capture result<=mac_out and result_valid<=1, and go to DONE.
- DONE:
  - result_valid and result are held until result_ready=1.
  - On that edge result_valid<=0 and state goes to IDLE.
  - result retains its value afterwards.
- busy=1 in CLEAR, RUN, DRAIN and DONE.
- start asserted outside IDLE is ignored; no queuing.
- Arithmetic: the maximum sum is 15*3*3=135, which fits in 8 bits. No overflow handling is required; mac_out is passed through unmodified.
- Reset asserted mid-job aborts it: FIFO flushed, no result produced. mac_clear is not pulsed on reset; the next job's CLEAR state clears the mac_unit.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE, CLEAR, RUN, DRAIN, DONE; 3 bits);
  - operand width 2;
  - accumulator width 8;
  - length width 4.
- One sub-module: mac_operand_fifo. It is a synchronous FIFO of {a,b} 4-bit entries, depth FIFO_DEPTH, with full/empty flags, the same asynchronous active-low reset and a flush input.

Test Plan:
- Basic: len=3, pairs (1,1),(2,2),(3,3) presented back-to-back -> exactly three mac_enable cycles, result=14, result_valid high until result_ready.
- Max length: len=15, all pairs (3,3), with in_valid continuous -> in_ready drops after the 15th accept, exactly 15 enables, result=135.
- Backpressure and bubbles: len=6 with in_valid toggling every other cycle, pairs (1,2)x6 -> no mac_enable during gaps, result=12, FIFO never overflows.
- Host stall: len=2, pairs (2,3),(1,1), result_ready held low 10 cycles -> result=7 stable and busy=1 throughout; a start pulse during the stall is ignored; IDLE is reached one edge after result_ready.
- Reset mid-RUN: len=5, reset low after 2 enables -> all outputs at reset values immediately (asynchronous). A new job with len=1, pair (3,2) -> mac_clear pulse, result=6.
- len=0: start with len=0, pair (2,2) -> treated as len=1, result=4, second offered pair not accepted.
